// File: rtl/nand_bus_sequencer.sv
// NAND flash bus-cycle generator: runs one CMD/ADDR/WRITE/READ/WAIT operation per START,
// strobing WE/RE with a half-period of DIV clocks. Every output is a flop.
module nand_bus_sequencer #(
    parameter int unsigned DIV         = 2,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_CYCLES = 5,
    parameter int unsigned LEN_W       = 12,
    parameter int unsigned TO_W        = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [2:0]                 op_i,
    input  logic                       hold_ce_i,
    input  logic [7:0]                 cmd_i,
    input  logic [8*ADDR_CYCLES-1:0]   addr_i,
    input  logic [LEN_W-1:0]           len_i,
    input  logic [TO_W-1:0]            timeout_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic                       wdata_pop_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       rdata_valid_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    input  logic                       prot_i,
    input  logic                       rb_ni,
    output logic                       ce_o,
    output logic                       cle_o,
    output logic                       ale_o,
    output logic                       we_o,
    output logic                       re_o,
    output logic                       wp_o,
    output logic [DATA_W-1:0]          io_o,
    output logic                       io_oe_o,
    input  logic [DATA_W-1:0]          io_i
);

    localparam int unsigned PhW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CntW = (LEN_W > 4) ? LEN_W : 4;
    localparam logic [PhW-1:0] PhLast = PhW'(DIV - 1);

    localparam logic [2:0] OpCmd   = 3'd0;
    localparam logic [2:0] OpAddr  = 3'd1;
    localparam logic [2:0] OpWrite = 3'd2;
    localparam logic [2:0] OpRead  = 3'd3;
    localparam logic [2:0] OpWait  = 3'd4;

    typedef enum logic [2:0] {StIdle, StLow, StHigh, StWait, StFin} state_e;

    state_e                   state_q;
    logic [2:0]               op_q;
    logic                     hold_q;
    logic [8*ADDR_CYCLES-1:0] addr_q;
    logic [CntW-1:0]          cnt_q;
    logic [PhW-1:0]           ph_q;
    logic [TO_W-1:0]          tcnt_q;
    logic                     rb_s1_q, rb_s2_q;
    logic                     pop_q, rvalid_q, busy_q, done_q, err_q;
    logic                     ce_q, cle_q, ale_q, we_q, re_q, wp_q, io_oe_q;
    logic [DATA_W-1:0]        rdata_q, io_q;

    // Enter the one-cycle DONE state and park the bus; CE stays asserted when held.
    task automatic go_fin(input logic hold, input logic err);
        state_q <= StFin;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        err_q   <= err;
        ce_q    <= ~hold;
        cle_q   <= 1'b0;
        ale_q   <= 1'b0;
        we_q    <= 1'b1;
        re_q    <= 1'b1;
        io_oe_q <= 1'b0;
        io_q    <= '0;
    endtask

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_q     <= OpCmd;
            hold_q   <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            ph_q     <= '0;
            tcnt_q   <= '0;
            rb_s1_q  <= 1'b1;
            rb_s2_q  <= 1'b1;
            pop_q    <= 1'b0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ce_q     <= 1'b1;
            cle_q    <= 1'b0;
            ale_q    <= 1'b0;
            we_q     <= 1'b1;
            re_q     <= 1'b1;
            wp_q     <= 1'b0;
            io_oe_q  <= 1'b0;
            rdata_q  <= '0;
            io_q     <= '0;
        end else begin
            rb_s1_q  <= rb_ni;
            rb_s2_q  <= rb_s1_q;
            wp_q     <= ~prot_i;
            done_q   <= 1'b0;
            pop_q    <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                StIdle, StFin: begin
                    if (start_i) begin
                        op_q   <= op_i;
                        hold_q <= hold_ce_i;
                        addr_q <= addr_i >> 8;
                        tcnt_q <= timeout_i;
                        ph_q   <= '0;
                        busy_q <= 1'b1;
                        ce_q   <= 1'b0;
                        err_q  <= 1'b0;
                        case (op_i)
                            OpCmd: begin
                                cnt_q   <= CntW'(1);
                                cle_q   <= 1'b1;
                                io_oe_q <= 1'b1;
                                io_q    <= DATA_W'(cmd_i);
                                we_q    <= 1'b0;
                                state_q <= StLow;
                            end
                            OpAddr: begin
                                cnt_q   <= CntW'(ADDR_CYCLES);
                                ale_q   <= 1'b1;
                                io_oe_q <= 1'b1;
                                io_q    <= DATA_W'(addr_i[7:0]);
                                we_q    <= 1'b0;
                                state_q <= StLow;
                            end
                            OpWrite: begin
                                if (len_i == '0) begin
                                    go_fin(hold_ce_i, 1'b0);
                                end else begin
                                    cnt_q   <= CntW'(len_i);
                                    io_oe_q <= 1'b1;
                                    io_q    <= wdata_i;
                                    pop_q   <= 1'b1;
                                    we_q    <= 1'b0;
                                    state_q <= StLow;
                                end
                            end
                            OpRead: begin
                                if (len_i == '0) begin
                                    go_fin(hold_ce_i, 1'b0);
                                end else begin
                                    cnt_q   <= CntW'(len_i);
                                    re_q    <= 1'b0;
                                    state_q <= StLow;
                                end
                            end
                            OpWait: begin
                                if (timeout_i == '0) go_fin(hold_ce_i, ~rb_s2_q);
                                else                 state_q <= StWait;
                            end
                            default: go_fin(hold_ce_i, 1'b1);
                        endcase
                    end else if (state_q == StFin) begin
                        state_q <= StIdle;
                    end
                end
                StLow: begin
                    if (ph_q == PhLast) begin
                        ph_q    <= '0;
                        we_q    <= 1'b1;
                        re_q    <= 1'b1;
                        state_q <= StHigh;
                        // Read data is captured on the edge that ends the RE-low phase.
                        if (op_q == OpRead) begin
                            rdata_q  <= io_i;
                            rvalid_q <= 1'b1;
                        end
                    end else begin
                        ph_q <= ph_q + PhW'(1);
                    end
                end
                StHigh: begin
                    if (ph_q != PhLast) begin
                        ph_q <= ph_q + PhW'(1);
                    end else if (cnt_q == CntW'(1)) begin
                        go_fin(hold_q, 1'b0);
                    end else begin
                        ph_q    <= '0;
                        cnt_q   <= cnt_q - CntW'(1);
                        state_q <= StLow;
                        if (op_q == OpRead) re_q <= 1'b0;
                        else                we_q <= 1'b0;
                        if (op_q == OpAddr) begin
                            io_q   <= DATA_W'(addr_q[7:0]);
                            addr_q <= addr_q >> 8;
                        end
                        if (op_q == OpWrite) begin
                            io_q  <= wdata_i;
                            pop_q <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (rb_s2_q)                      go_fin(hold_q, 1'b0);
                    else if (tcnt_q == TO_W'(1))      go_fin(hold_q, 1'b1);
                    else                              tcnt_q <= tcnt_q - TO_W'(1);
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wdata_pop_o   = pop_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign ce_o          = ce_q;
    assign cle_o         = cle_q;
    assign ale_o         = ale_q;
    assign we_o          = we_q;
    assign re_o          = re_q;
    assign wp_o          = wp_q;
    assign io_o          = io_q;
    assign io_oe_o       = io_oe_q;

endmodule
